// File: rtl/hdb3_pkg.sv
// Shared HDB3 definitions.
//   sym_e : dual-rail symbol encoding, packed as {p, n}
//   LAT   : decoder latency in symbols (bit for symbol k leaves on symbol k+LAT)
package hdb3_pkg;

  typedef enum logic [1:0] {
    SYM_Z   = 2'b00,
    SYM_N   = 2'b01,
    SYM_P   = 2'b10,
    SYM_ILL = 2'b11
  } sym_e;

  localparam int unsigned LAT = 4;

endpackage

// File: rtl/hdb3_decoder_sym_tick.sv
// Symbol-rate timing for the HDB3 receiver.
// Divides clk by DIV into a 50% duty sym_clk and a one-clk tick that fires
// on the cycle whose edge takes sym_clk from 1 to 0 (once every DIV clk).
//   clk     : system clock
//   rst     : synchronous active-low reset
//   sym_clk : recovered symbol clock
//   tick    : one-clk strobe, decoding happens on the edge that ends it
module sym_tick #(
  parameter int unsigned DIV = 16,
  parameter int unsigned CW  = 4
) (
  input  logic clk,
  input  logic rst,
  output logic sym_clk,
  output logic tick
);

  localparam logic [CW-1:0] HALF_MAX = CW'(DIV / 2 - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sym_clk_q, sym_clk_d;
  logic          wrap;

  always_comb begin
    wrap      = (cnt_q == HALF_MAX);
    cnt_d     = wrap ? '0 : cnt_q + CW'(1);
    sym_clk_d = wrap ? ~sym_clk_q : sym_clk_q;
    tick      = wrap & sym_clk_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      sym_clk_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      sym_clk_q <= sym_clk_d;
    end
  end

  assign sym_clk = sym_clk_q;

endmodule

// File: rtl/hdb3_decoder.sv
// HDB3 receive decoder.
// Samples the dual-rail line once per symbol tick, classifies B / V / zero,
// strips 000V and B00V substitutions through a LAT-deep delay line and
// emits the recovered NRZ stream.
//   clk        : system clock
//   rst        : synchronous active-low reset
//   code_p     : positive-pulse rail
//   code_n     : negative-pulse rail
//   data_out   : decoded bit, updated on ticks
//   data_valid : one-clk pulse when data_out carries a new bit
//   v_det      : one-clk pulse when the sampled symbol was a V pulse
//   err        : one-clk pulse on a line-code error
//   sym_clk    : recovered symbol clock (period DIV)
module hdb3_decoder
  import hdb3_pkg::*;
#(
  parameter int unsigned DIV = 16,
  parameter int unsigned CW  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic code_p,
  input  logic code_n,
  output logic data_out,
  output logic data_valid,
  output logic v_det,
  output logic err,
  output logic sym_clk
);

  localparam int unsigned FW = $clog2(LAT + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(LAT);
  localparam logic [2:0]    ZRUN_MAX  = 3'd4;

  logic tick;

  sym_tick #(
    .DIV (DIV),
    .CW  (CW)
  ) u_sym_tick (
    .clk     (clk),
    .rst     (rst),
    .sym_clk (sym_clk),
    .tick    (tick)
  );

  logic [LAT-1:0] sr_q, sr_d;
  logic [FW-1:0]  fill_q, fill_d;
  logic [2:0]     zrun_q, zrun_d;
  logic           last_pol_q, last_pol_d;
  logic           have_pulse_q, have_pulse_d;
  logic           last_vpol_q, last_vpol_d;
  logic           have_v_q, have_v_d;
  logic           data_out_q, data_out_d;
  logic           data_valid_q, data_valid_d;
  logic           v_det_q, v_det_d;
  logic           err_q, err_d;

  sym_e sym;
  logic pulse;
  logic pol;
  logic is_v;

  always_comb begin
    sym   = sym_e'({code_p, code_n});
    pulse = (sym == SYM_P) || (sym == SYM_N);
    pol   = (sym == SYM_P);
    is_v  = pulse && have_pulse_q && (pol == last_pol_q);

    sr_d         = sr_q;
    fill_d       = fill_q;
    zrun_d       = zrun_q;
    last_pol_d   = last_pol_q;
    have_pulse_d = have_pulse_q;
    last_vpol_d  = last_vpol_q;
    have_v_d     = have_v_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    v_det_d      = 1'b0;
    err_d        = 1'b0;

    if (tick) begin
      data_out_d   = sr_q[LAT-1];
      data_valid_d = (fill_q == FILL_FULL);
      if (fill_q != FILL_FULL) fill_d = fill_q + FW'(1);

      if (is_v) begin
        // Shift and clear in one step: the three symbols before V move up
        // to sr[3:1] and are zeroed along with the V bit itself, so the
        // whole delay line becomes zero (removes B of B00V).
        sr_d        = '0;
        v_det_d     = 1'b1;
        if (have_v_q && (pol == last_vpol_q)) err_d = 1'b1;
        have_v_d    = 1'b1;
        last_vpol_d = pol;
      end else begin
        sr_d = {sr_q[LAT-2:0], pulse};
      end

      if (pulse) begin
        have_pulse_d = 1'b1;
        last_pol_d   = pol;
        zrun_d       = '0;
      end else begin
        // Illegal symbols count as zeros; error fires on the 4th zero only.
        if (zrun_q == 3'd3) err_d = 1'b1;
        if (zrun_q != ZRUN_MAX) zrun_d = zrun_q + 3'd1;
      end

      if (sym == SYM_ILL) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_q         <= '0;
      fill_q       <= '0;
      zrun_q       <= '0;
      last_pol_q   <= 1'b0;
      have_pulse_q <= 1'b0;
      last_vpol_q  <= 1'b0;
      have_v_q     <= 1'b0;
      data_out_q   <= 1'b0;
      data_valid_q <= 1'b0;
      v_det_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      fill_q       <= fill_d;
      zrun_q       <= zrun_d;
      last_pol_q   <= last_pol_d;
      have_pulse_q <= have_pulse_d;
      last_vpol_q  <= last_vpol_d;
      have_v_q     <= have_v_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      v_det_q      <= v_det_d;
      err_q        <= err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign v_det      = v_det_q;
  assign err        = err_q;

endmodule

// File: tb/tb_hdb3_decoder.sv
// Scoreboard bench for hdb3_decoder: a symbol-level reference model pushes
// expected tick events; a negedge monitor pops them when the DUT pulses.
module tb_hdb3_decoder;

  localparam int unsigned DIV = 16;
  localparam int unsigned CW  = 4;

  localparam logic [1:0] SZ = 2'b00;
  localparam logic [1:0] SN = 2'b01;
  localparam logic [1:0] SP = 2'b10;
  localparam logic [1:0] SX = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic code_p = 1'b0;
  logic code_n = 1'b0;
  logic data_out, data_valid, v_det, err, sym_clk;

  hdb3_decoder #(
    .DIV (DIV),
    .CW  (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .code_p     (code_p),
    .code_n     (code_n),
    .data_out   (data_out),
    .data_valid (data_valid),
    .v_det      (v_det),
    .err        (err),
    .sym_clk    (sym_clk)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int unsigned stamp;
    logic        valid;
    logic        data;
    logic        v;
    logic        e;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: any DUT event must match the next expected record.
  always @(negedge clk) begin
    if (data_valid || v_det || err) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: valid=%0d v=%0d err=%0d at cycle %0d",
                 data_valid, v_det, err, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("event_cycle", int'(cyc), int'(e.stamp));
        chk("data_valid", int'(data_valid), int'(e.valid));
        chk("v_det", int'(v_det), int'(e.v));
        chk("err", int'(err), int'(e.e));
        if (e.valid) chk("data_out", int'(data_out), int'(e.data));
      end
    end
  end

  int unsigned rel;

  task automatic do_reset(input int unsigned ncyc);
    @(negedge clk);
    rst    = 1'b0;
    code_p = 1'b0;
    code_n = 1'b0;
    repeat (ncyc) @(posedge clk);
    @(negedge clk);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_data_valid", int'(data_valid), 0);
    chk("rst_v_det", int'(v_det), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_sym_clk", int'(sym_clk), 0);
    rel = cyc;
    rst = 1'b1;
  endtask

  // Reference: decode symbol by symbol into a bit list; a V rewrites the
  // last four list entries (three predecessors plus itself) to 0.
  task automatic run_stream(input logic [1:0] syms[$], input int unsigned nrst,
                            input bit chk_div);
    bit   have_p, lastp, have_v, lastv;
    int   zrun;
    bit   bits[$];
    logic p, n;
    exp_t r;
    have_p = 0; lastp = 0; have_v = 0; lastv = 0; zrun = 0;
    do_reset(nrst);
    for (int k = 1; k <= syms.size(); k++) begin
      p = syms[k-1][1];
      n = syms[k-1][0];
      code_p = p;
      code_n = n;
      r.stamp = rel + DIV * k;
      r.e = p && n;
      r.v = 0;
      if (p != n) begin
        if (have_p && p == lastp) begin
          r.v = 1;
          if (have_v && lastv == p) r.e = 1;
          have_v = 1;
          lastv  = p;
          bits.push_back(1'b0);
          for (int i = bits.size() - 4; i < bits.size(); i++)
            if (i >= 0) bits[i] = 1'b0;
        end else begin
          bits.push_back(1'b1);
        end
        have_p = 1;
        lastp  = p;
        zrun   = 0;
      end else begin
        bits.push_back(1'b0);
        zrun++;
        if (zrun == 4) r.e = 1;
      end
      r.valid = (k >= 5);
      r.data  = r.valid ? bits[k-5] : 1'b0;
      if (r.valid || r.v || r.e) sb.push_back(r);
      for (int c = 0; c < int'(DIV); c++) begin
        @(negedge clk);
        if (chk_div && k <= 3)
          chk("sym_clk", int'(sym_clk), int'(((cyc - rel) / (DIV / 2)) % 2));
      end
    end
    #1;
    chk("drain", sb.size(), 0);
    sb.delete();
  endtask

  logic [1:0] s[$];

  initial begin
    s = '{SP, SN, SP, SN, SP, SN, SP, SN};
    run_stream(s, 3, 1'b1);
    s = '{SP, SZ, SZ, SZ, SP, SN, SP, SN, SP};
    run_stream(s, 2, 1'b0);
    s = '{SP, SN, SZ, SZ, SN, SP, SZ, SZ, SP, SN, SP, SN, SP};
    run_stream(s, 2, 1'b0);
    s = '{SP, SN, SX, SP, SN, SP, SN};
    run_stream(s, 2, 1'b0);
    s = '{SP, SZ, SZ, SZ, SZ, SZ, SP, SN};
    run_stream(s, 2, 1'b0);
    s = '{SP, SN, SN, SP, SN, SN, SP, SN};
    run_stream(s, 2, 1'b0);
    // Stream cut after tick 6 by the following reset; restart must be clean.
    s = '{SP, SN, SZ, SZ, SP, SN};
    run_stream(s, 2, 1'b0);
    s = '{SN, SP, SN, SP, SN, SP, SN};
    run_stream(s, 2, 1'b0);
    for (int t = 0; t < 6; t++) begin
      int unsigned len;
      int unsigned w;
      len = $urandom_range(40, 20);
      s.delete();
      for (int i = 0; i < int'(len); i++) begin
        w = $urandom_range(99, 0);
        if (w < 40)      s.push_back(SZ);
        else if (w < 69) s.push_back(SP);
        else if (w < 98) s.push_back(SN);
        else             s.push_back(SX);
      end
      run_stream(s, 2, 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
